branch_target_predictor: RTL

Parametrised successor to the 8-entry 2-bit predictor in the hazard handling unit. It is a direct-mapped, tagged branch target buffer with N-bit saturating counters and stored targets. The ID stage performs a combinational lookup. The EX stage resolves the branch and updates the table on the clock edge. On a misprediction, the block drives the flush signal and the redirect PC, and it keeps saturating branch and mispredict counters.

---
 rtl/branch_target_predictor_if.sv | 40 ++++
 rtl/branch_target_predictor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor_if.sv
// Predictor bus between the ID/EX pipeline and the branch target buffer.
// The pipeline drives lookups and resolutions; the predictor answers.
interface branch_target_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ID_PC;
  logic                  ID_STAGE_BRANCH;
  logic                  PREDICT_TAKEN;
  logic [ADDR_WIDTH-1:0] PREDICT_TARGET;
  logic                  EX_BRANCH;
  logic [ADDR_WIDTH-1:0] EX_PC;
  logic                  EX_TAKEN;
  logic [ADDR_WIDTH-1:0] EX_TARGET;
  logic                  EX_PRED_TAKEN;
  logic [ADDR_WIDTH-1:0] EX_PRED_TARGET;
  logic                  STALL;
  logic                  FLUSH;
  logic [ADDR_WIDTH-1:0] REDIRECT_PC;
  logic [STAT_WIDTH-1:0] BRANCH_COUNT;
  logic [STAT_WIDTH-1:0] MISPREDICT_COUNT;

  modport master (
    output ID_PC, ID_STAGE_BRANCH,
    output EX_BRANCH, EX_PC, EX_TAKEN, EX_TARGET,
    output EX_PRED_TAKEN, EX_PRED_TARGET, STALL,
    input  PREDICT_TAKEN, PREDICT_TARGET,
    input  FLUSH, REDIRECT_PC,
    input  BRANCH_COUNT, MISPREDICT_COUNT
  );

  modport slave (
    input  ID_PC, ID_STAGE_BRANCH,
    input  EX_BRANCH, EX_PC, EX_TAKEN, EX_TARGET,
    input  EX_PRED_TAKEN, EX_PRED_TARGET, STALL,
    output PREDICT_TAKEN, PREDICT_TARGET,
    output FLUSH, REDIRECT_PC,
    output BRANCH_COUNT, MISPREDICT_COUNT
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged branch target buffer with saturating counters.
// ID looks up combinationally; EX resolves, flushes and updates on the edge.
module branch_target_predictor #(
  parameter int INDEX_BITS   = 3,
  parameter int TAG_BITS     = 8,
  parameter int COUNTER_BITS = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int STAT_WIDTH   = 32
) (
  input logic CLK,
  input logic RESET,
  branch_target_predictor_if.slave bus
);

  localparam int N = 1 << INDEX_BITS;
  localparam int TLO = INDEX_BITS + 2;
  localparam int THI = INDEX_BITS + TAG_BITS + 1;
  localparam logic [COUNTER_BITS-1:0] WNT =
    {1'b0, {(COUNTER_BITS-1){1'b1}}};
  localparam logic [COUNTER_BITS-1:0] WT =
    {1'b1, {(COUNTER_BITS-1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  logic                    valid_q [N];
  logic [TAG_BITS-1:0]     tag_q   [N];
  logic [ADDR_WIDTH-1:0]   tgt_q   [N];
  logic [COUNTER_BITS-1:0] ctr_q   [N];

  logic [STAT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;

  logic [INDEX_BITS-1:0] id_idx, ex_idx;
  logic [TAG_BITS-1:0]   id_tag, ex_tag;
  logic                  id_hit, ex_hit;
  logic                  pred_tk;
  logic                  resolve, mispredict, flush;

  logic                    we;
  logic                    wr_valid;
  logic [TAG_BITS-1:0]     wr_tag;
  logic [ADDR_WIDTH-1:0]   wr_tgt;
  logic [COUNTER_BITS-1:0] wr_ctr;

  logic unused_pc;

  assign unused_pc = ^{bus.ID_PC, bus.EX_PC};

  assign id_idx = bus.ID_PC[INDEX_BITS+1:2];
  assign id_tag = bus.ID_PC[THI:TLO];
  assign ex_idx = bus.EX_PC[INDEX_BITS+1:2];
  assign ex_tag = bus.EX_PC[THI:TLO];

  assign id_hit  = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign pred_tk = bus.ID_STAGE_BRANCH && id_hit
                && (ctr_q[id_idx] >= WT);

  assign resolve    = bus.EX_BRANCH && !bus.STALL;
  assign mispredict = (bus.EX_PRED_TAKEN != bus.EX_TAKEN)
                   || (bus.EX_TAKEN
                       && (bus.EX_PRED_TARGET != bus.EX_TARGET));
  assign flush      = resolve && mispredict;

  assign bus.PREDICT_TAKEN  = RESET && pred_tk;
  assign bus.PREDICT_TARGET = !RESET ? '0
                            : pred_tk ? tgt_q[id_idx]
                            : bus.ID_PC + FOUR;
  assign bus.FLUSH       = RESET && flush;
  assign bus.REDIRECT_PC = !RESET ? '0
                         : bus.EX_TAKEN ? bus.EX_TARGET
                         : bus.EX_PC + FOUR;

  assign bus.BRANCH_COUNT     = br_cnt_q;
  assign bus.MISPREDICT_COUNT = mp_cnt_q;

  // Build the new contents of the EX-indexed entry for this resolve.
  always_comb begin
    we       = 1'b0;
    wr_valid = valid_q[ex_idx];
    wr_tag   = tag_q[ex_idx];
    wr_tgt   = tgt_q[ex_idx];
    wr_ctr   = ctr_q[ex_idx];
    if (resolve) begin
      if (ex_hit) begin
        we = 1'b1;
        if (bus.EX_TAKEN) begin
          wr_tgt = bus.EX_TARGET;
          if (ctr_q[ex_idx] != '1)
            wr_ctr = ctr_q[ex_idx] + 1'b1;
        end else if (ctr_q[ex_idx] != '0) begin
          wr_ctr = ctr_q[ex_idx] - 1'b1;
        end
      end else if (bus.EX_TAKEN) begin
        we       = 1'b1;
        wr_valid = 1'b1;
        wr_tag   = ex_tag;
        wr_tgt   = bus.EX_TARGET;
        wr_ctr   = WT;
      end
    end
  end

  // Saturating statistics; they never wrap back to zero.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && br_cnt_q != '1)
      br_cnt_d = br_cnt_q + 1'b1;
    if (flush && mp_cnt_q != '1)
      mp_cnt_d = mp_cnt_q + 1'b1;
  end

  // Table storage; reset clears every entry and wins over a pending write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
    end else if (we) begin
      valid_q[ex_idx] <= wr_valid;
      tag_q[ex_idx]   <= wr_tag;
      tgt_q[ex_idx]   <= wr_tgt;
      ctr_q[ex_idx]   <= wr_ctr;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

endmodule
